// File: rtl/spi_fifo_tx_pkg.sv
// Shared definitions for the FIFO-to-SPI transmit path.
//   TRUE/FALSE : FIFO flag polarity (the FIFO drives its flags active-low)
//   state_t    : transmit FSM state encoding
//   cnt_width  : counter width helper that never returns zero
package spi_fifo_tx_pkg;

    localparam logic TRUE  = 1'b0;
    localparam logic FALSE = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        POP_HI = 3'd1,
        POP_LO = 3'd2,
        LOAD   = 3'd3,
        SHIFT  = 3'd4
    } state_t;

    // Width of a counter that must hold values 0..n-1; at least one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_fifo_tx_tick.sv
// spi_tick_gen: sclk half-period divider.
//   clk, rst     : clock, async active-high reset
//   run          : advance the divider (only while shifting)
//   load         : synchronous clear of divider and sclk, masks the ticks
//   sclk         : registered SPI clock, idles low
//   rise_tick_c  : sclk goes high at the coming clk edge
//   fall_tick_c  : sclk goes low at the coming clk edge
module spi_tick_gen
    import spi_fifo_tx_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic load,
    output logic sclk,
    output logic rise_tick_c,
    output logic fall_tick_c
);

    localparam int unsigned DIV_W = cnt_width(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic             wrap_c;

    // The ticks announce the edge that the register below is about to make.
    assign wrap_c      = run && !load && (div_cnt == DIV_LAST);
    assign rise_tick_c = wrap_c && !sclk;
    assign fall_tick_c = wrap_c && sclk;

    // Divider and sclk phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            sclk    <= 1'b0;
        end else if (load) begin
            div_cnt <= '0;
            sclk    <= 1'b0;
        end else if (run) begin
            if (div_cnt == DIV_LAST) begin
                div_cnt <= '0;
                sclk    <= ~sclk;
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/spi_fifo_tx.sv
// spi_fifo_tx: pops bytes from the edge-strobed FIFO and sends them as an
// SPI mode-0 master, MSB first, holding cs_n low across back-to-back bytes.
//   clk, rst : clock, async active-high reset
//   en       : permission to start a new byte (checked in IDLE / at byte end)
//   empty    : FIFO empty flag, active-low (1 = data available)
//   odat     : FIFO read data, valid the cycle after a pop
//   oen      : pop strobe; the FIFO pops on its 1->0 transition
//   sclk     : SPI clock, idles low
//   mosi     : SPI data, changes while sclk is low
//   cs_n     : SPI chip select, active low
//   busy     : high whenever the FSM is not IDLE
module spi_fifo_tx
    import spi_fifo_tx_pkg::*;
#(
    parameter int unsigned DW      = 8,
    parameter int unsigned CLK_DIV = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          empty,
    input  logic [DW-1:0] odat,
    output logic          oen,
    output logic          sclk,
    output logic          mosi,
    output logic          cs_n,
    output logic          busy
);

    localparam int unsigned BIT_W = cnt_width(DW);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DW - 1);

    state_t           state, state_n;
    logic             oen_n, mosi_n, cs_n_n, busy_n;
    logic [DW-1:0]    shreg, shreg_n;
    logic [BIT_W-1:0] bit_cnt, bit_cnt_n;
    logic             last_bit, last_bit_n;
    logic             tick_run_c, tick_load_c;
    logic             rise_tick_c, fall_tick_c;
    logic             start_c;

    assign start_c = en && (empty == FALSE);

    spi_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk         (clk),
        .rst         (rst),
        .run         (tick_run_c),
        .load        (tick_load_c),
        .sclk        (sclk),
        .rise_tick_c (rise_tick_c),
        .fall_tick_c (fall_tick_c)
    );

    // Next-state and next-output decode.
    always_comb begin
        state_n     = state;
        oen_n       = 1'b0;
        mosi_n      = mosi;
        cs_n_n      = cs_n;
        shreg_n     = shreg;
        bit_cnt_n   = bit_cnt;
        last_bit_n  = last_bit;
        tick_run_c  = 1'b0;
        tick_load_c = 1'b0;

        case (state)
            IDLE: begin
                if (start_c) begin
                    state_n = POP_HI;
                    oen_n   = 1'b1;
                end
            end
            POP_HI: state_n = POP_LO;
            POP_LO: state_n = LOAD;
            LOAD: begin
                state_n     = SHIFT;
                shreg_n     = odat;
                cs_n_n      = 1'b0;
                mosi_n      = odat[DW-1];
                bit_cnt_n   = '0;
                last_bit_n  = 1'b0;
                tick_load_c = 1'b1;
            end
            SHIFT: begin
                tick_run_c = 1'b1;
                // Remember that the final bit has been clocked, so the
                // following fall closes the byte instead of shifting.
                if (rise_tick_c && (bit_cnt == BIT_LAST)) begin
                    last_bit_n = 1'b1;
                end
                if (fall_tick_c) begin
                    if (last_bit) begin
                        if (start_c) begin
                            state_n = POP_HI;
                            oen_n   = 1'b1;
                        end else begin
                            state_n = IDLE;
                            cs_n_n  = 1'b1;
                        end
                    end else begin
                        shreg_n   = {shreg[DW-2:0], 1'b0};
                        mosi_n    = shreg[DW-2];
                        bit_cnt_n = bit_cnt + BIT_W'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        busy_n = (state_n != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            oen      <= 1'b0;
            mosi     <= 1'b0;
            cs_n     <= 1'b1;
            busy     <= 1'b0;
            shreg    <= '0;
            bit_cnt  <= '0;
            last_bit <= 1'b0;
        end else begin
            state    <= state_n;
            oen      <= oen_n;
            mosi     <= mosi_n;
            cs_n     <= cs_n_n;
            busy     <= busy_n;
            shreg    <= shreg_n;
            bit_cnt  <= bit_cnt_n;
            last_bit <= last_bit_n;
        end
    end

endmodule

// File: tb/tb_spi_fifo_tx.sv
// Bench for spi_fifo_tx: two instances (CLK_DIV=2 and CLK_DIV=1), each fed by
// a behavioural 15-entry FIFO, a per-cycle waveform model and an SPI receiver.
module tb_spi_fifo_tx;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        en, empty, oen, sclk, mosi, cs_n, busy;
    logic [1:0][7:0]   odat;
    logic [1:0]        push_v;
    logic [1:0][7:0]   push_d;

    always #5 clk = ~clk;

    spi_fifo_tx #(.DW(8), .CLK_DIV(2)) dut0 (
        .clk(clk), .rst(rst), .en(en[0]), .empty(empty[0]), .odat(odat[0]),
        .oen(oen[0]), .sclk(sclk[0]), .mosi(mosi[0]), .cs_n(cs_n[0]), .busy(busy[0]));

    spi_fifo_tx #(.DW(8), .CLK_DIV(1)) dut1 (
        .clk(clk), .rst(rst), .en(en[1]), .empty(empty[1]), .odat(odat[1]),
        .oen(oen[1]), .sclk(sclk[1]), .mosi(mosi[1]), .cs_n(cs_n[1]), .busy(busy[1]));

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    function automatic int cd(input int d);
        return (d == 0) ? 2 : 1;
    endfunction

    task automatic chk(input string nm, input int d, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s dut%0d cycle %0d: got %0h expected %0h", nm, d, cyc, act, exp);
        end
    endtask

    // ---------------- FIFO model and transfer-position model ----------------
    logic [7:0] mem [2][16];
    int         wp[2], rp[2], fcnt[2], pos[2];
    logic       fo_d[2], chained[2];
    logic [7:0] mbyte[2];

    assign empty[0] = (fcnt[0] != 0);
    assign empty[1] = (fcnt[1] != 0);

    always @(posedge clk) cyc <= cyc + 1;

    // pos = cycles since the oen rise of the current byte, -1 when idle.
    // A byte occupies 3 + 2*CLK_DIV*8 cycles; the next one may start right after.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int d = 0; d < 2; d++) begin
                wp[d] <= 0; rp[d] <= 0; fcnt[d] <= 0; fo_d[d] <= 1'b0;
                pos[d] <= -1; chained[d] <= 1'b0; mbyte[d] <= 8'h00; odat[d] <= 8'h00;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                int  blen;
                bit  pop, pok, go;
                blen = 3 + 2 * cd(d) * 8;
                pop  = fo_d[d] && !oen[d] && (fcnt[d] != 0);
                pok  = push_v[d] && (fcnt[d] < 15);
                go   = en[d] && (fcnt[d] != 0);
                fo_d[d] <= oen[d];
                if (pop) begin
                    odat[d] <= mem[d][rp[d]];
                    rp[d]   <= (rp[d] + 1) % 16;
                end
                if (pok) begin
                    mem[d][wp[d]] <= push_d[d];
                    wp[d]         <= (wp[d] + 1) % 16;
                end
                fcnt[d] <= fcnt[d] + (pok ? 1 : 0) - (pop ? 1 : 0);
                if (pos[d] < 0 || pos[d] == blen - 1) begin
                    if (go) begin
                        pos[d]     <= 0;
                        chained[d] <= (pos[d] >= 0);
                        mbyte[d]   <= mem[d][rp[d]];
                    end else begin
                        pos[d] <= -1;
                    end
                end else begin
                    pos[d] <= pos[d] + 1;
                end
            end
        end
    end

    // ---------------- per-cycle compare against the model ----------------
    always @(negedge clk) begin
        if (!rst) begin
            for (int d = 0; d < 2; d++) begin
                int         s;
                logic [3:0] ev;
                s  = pos[d] - 3;
                if (pos[d] < 0)      ev = 4'b0100;
                else if (pos[d] < 3) ev = {pos[d] == 0, !chained[d], 1'b0, 1'b1};
                else                 ev = {1'b0, 1'b0, ((s / cd(d)) % 2) == 1, 1'b1};
                chk("ctrl{oen,cs_n,sclk,busy}", d, 32'({oen[d], cs_n[d], sclk[d], busy[d]}), 32'(ev));
                if (pos[d] >= 3)
                    chk("mosi", d, 32'(mosi[d]), 32'(mbyte[d][7 - s / (2 * cd(d))]));
            end
        end
    end

    // ---------------- SPI receiver / event monitor ----------------
    int         rise_n[2]     = '{0, 0};
    int         rise_t[2][1024];
    int         rx_n[2]       = '{0, 0};
    logic [7:0] rx_log[2][256];
    logic [7:0] rx_sh[2];
    int         rx_bits[2]    = '{0, 0};
    int         oen_rise_n[2] = '{0, 0};
    int         oen_rise_t[2] = '{0, 0};
    int         oen_fall_t[2] = '{0, 0};
    int         csf_t[2]      = '{0, 0};
    int         csr_n[2]      = '{0, 0};
    logic       ps[2], po[2], pc[2];

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                rx_bits[d] = 0; ps[d] = 1'b0; po[d] = 1'b0; pc[d] = 1'b1;
            end else begin
                if (sclk[d] && !ps[d]) begin
                    if (rise_n[d] < 1024) rise_t[d][rise_n[d]] = cyc;
                    rise_n[d]++;
                    if (!cs_n[d]) begin
                        rx_sh[d] = {rx_sh[d][6:0], mosi[d]};
                        rx_bits[d]++;
                        if (rx_bits[d] == 8) begin
                            if (rx_n[d] < 256) rx_log[d][rx_n[d]] = rx_sh[d];
                            rx_n[d]++;
                            rx_bits[d] = 0;
                        end
                    end
                end
                if (oen[d] && !po[d]) begin oen_rise_t[d] = cyc; oen_rise_n[d]++; end
                if (!oen[d] && po[d]) oen_fall_t[d] = cyc;
                if (!cs_n[d] && pc[d]) csf_t[d] = cyc;
                if (cs_n[d] && !pc[d]) csr_n[d]++;
                ps[d] = sclk[d]; po[d] = oen[d]; pc[d] = cs_n[d];
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic push(input int d, input logic [7:0] b);
        @(negedge clk);
        push_v[d] = 1'b1;
        push_d[d] = b;
        @(negedge clk);
        push_v[d] = 1'b0;
    endtask

    task automatic wait_rx(input int d, input int n, input int budget, input string nm);
        int k = 0;
        while (rx_n[d] < n && k < budget) begin @(posedge clk); k++; end
        chk(nm, d, rx_n[d], n);
    endtask

    task automatic wait_idle(input int d, input int budget, input string nm);
        int k = 0;
        while (busy[d] && k < budget) begin @(posedge clk); k++; end
        chk(nm, d, 32'(busy[d]), 0);
    endtask

    task automatic wait_rises(input int d, input int n, input int budget, input string nm);
        int k = 0;
        while (rise_n[d] < n && k < budget) begin @(posedge clk); k++; end
        chk(nm, d, (rise_n[d] >= n) ? 1 : 0, 1);
    endtask

    logic [7:0] exp_q[$];

    initial begin
        int rb, r0, c0, r;
        rst = 1'b1; en = 2'b00; push_v = 2'b00; push_d = '0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++)
            chk("reset{oen,sclk,mosi,cs_n,busy}", d,
                32'({oen[d], sclk[d], mosi[d], cs_n[d], busy[d]}), 32'h02);
        rst = 1'b0;

        // 1: empty FIFO with en high never pops.
        en = 2'b11;
        repeat (100) @(negedge clk);
        chk("t1_no_pop", 0, oen_rise_n[0], 0);
        chk("t1_no_pop", 1, oen_rise_n[1], 0);
        chk("t1_cs_n", 0, 32'(cs_n[0]), 1);
        en[1] = 1'b0;

        // 2: single byte, latency and bit spacing.
        rb = rx_n[0]; r0 = rise_n[0];
        push(0, 8'hA5);
        wait_rx(0, rb + 1, 200, "t2_rx_timeout");
        chk("t2_byte", 0, 32'(rx_log[0][rb]), 32'hA5);
        chk("t2_oen_to_csn", 0, csf_t[0] - oen_rise_t[0], 3);
        chk("t2_oen_width", 0, oen_fall_t[0] - oen_rise_t[0], 1);
        chk("t2_first_rise", 0, rise_t[0][r0] - csf_t[0], 2);
        chk("t2_rise_span", 0, rise_t[0][r0 + 7] - rise_t[0][r0], 28);
        wait_idle(0, 50, "t2_idle");
        chk("t2_cs_n_high", 0, 32'(cs_n[0]), 1);

        // 3: three chained bytes under one cs_n.
        rb = rx_n[0]; r0 = rise_n[0]; c0 = csr_n[0];
        push(0, 8'h3C); push(0, 8'hFF); push(0, 8'h00);
        wait_rx(0, rb + 3, 400, "t3_rx_timeout");
        wait_idle(0, 50, "t3_idle");
        chk("t3_byte0", 0, 32'(rx_log[0][rb]), 32'h3C);
        chk("t3_byte1", 0, 32'(rx_log[0][rb + 1]), 32'hFF);
        chk("t3_byte2", 0, 32'(rx_log[0][rb + 2]), 32'h00);
        chk("t3_rises", 0, rise_n[0] - r0, 24);
        chk("t3_cs_rises", 0, csr_n[0] - c0, 1);
        chk("t3_gap", 0, rise_t[0][r0 + 8] - rise_t[0][r0 + 7], 7);
        chk("t3_fifo_empty", 0, fcnt[0], 0);

        // 4: en dropped mid-byte finishes the byte and leaves the rest queued.
        en[0] = 1'b0;
        rb = rx_n[0]; r0 = rise_n[0];
        push(0, 8'h81); push(0, 8'h42);
        @(negedge clk); en[0] = 1'b1;
        wait_rises(0, r0 + 1, 50, "t4_start_timeout");
        @(negedge clk); en[0] = 1'b0;
        wait_rx(0, rb + 1, 200, "t4_rx1_timeout");
        wait_idle(0, 50, "t4_idle1");
        repeat (20) @(negedge clk);
        chk("t4_byte0", 0, 32'(rx_log[0][rb]), 32'h81);
        chk("t4_held", 0, rx_n[0], rb + 1);
        chk("t4_fifo_one", 0, fcnt[0], 1);
        en[0] = 1'b1;
        wait_rx(0, rb + 2, 200, "t4_rx2_timeout");
        chk("t4_byte1", 0, 32'(rx_log[0][rb + 1]), 32'h42);
        wait_idle(0, 50, "t4_idle2");

        // Random pushes with en toggling; every pushed byte must arrive in order.
        rb = rx_n[0];
        exp_q.delete();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            en[0]     = ($urandom_range(0, 3) != 0);
            push_v[0] = 1'b0;
            if ($urandom_range(0, 2) == 0 && fcnt[0] < 15) begin
                push_d[0] = 8'($urandom);
                push_v[0] = 1'b1;
                exp_q.push_back(push_d[0]);
            end
        end
        @(negedge clk); push_v[0] = 1'b0; en[0] = 1'b1;
        wait_rx(0, rb + exp_q.size(), 4000, "rand_rx_timeout");
        wait_idle(0, 50, "rand_idle");
        for (int i = 0; i < exp_q.size(); i++)
            chk("rand_byte", 0, 32'(rx_log[0][rb + i]), 32'(exp_q[i]));

        // 5: reset in the middle of bit 4.
        r0 = rise_n[0];
        push(0, 8'hC3);
        wait_rises(0, r0 + 5, 100, "t5_bit4_timeout");
        @(posedge clk); #2 rst = 1'b1;
        #1 chk("t5_rst{oen,sclk,cs_n,busy}", 0, 32'({oen[0], sclk[0], cs_n[0], busy[0]}), 32'b0010);
        r = rise_n[0];
        @(negedge clk); @(negedge clk); rst = 1'b0;
        repeat (50) @(negedge clk);
        chk("t5_no_sclk", 0, rise_n[0], r);
        chk("t5_cs_n", 0, 32'(cs_n[0]), 1);

        // 6: CLK_DIV=1, full FIFO drained in order.
        en[1] = 1'b0;
        for (int i = 1; i <= 15; i++) push(1, 8'(i));
        @(negedge clk);
        chk("t6_fifo_full", 1, fcnt[1], 15);
        rb = rx_n[1]; r0 = rise_n[1]; c0 = csr_n[1];
        en[1] = 1'b1;
        wait_rx(1, rb + 15, 1000, "t6_rx_timeout");
        wait_idle(1, 50, "t6_idle");
        for (int i = 0; i < 15; i++)
            chk("t6_byte", 1, 32'(rx_log[1][rb + i]), i + 1);
        chk("t6_rise_span", 1, rise_t[1][r0 + 7] - rise_t[1][r0], 14);
        chk("t6_byte_period", 1, rise_t[1][r0 + 8] - rise_t[1][r0], 19);
        chk("t6_cs_rises", 1, csr_n[1] - c0, 1);
        chk("t6_fifo_empty", 1, fcnt[1], 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", n_errors);
        $fatal(1, "watchdog expired");
    end

endmodule
